// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the change payout controller.
//   - denomination codes DEN_1..DEN_50 (code order = ascending value)
//   - value_of(): code -> face value in units
//   - state_t and the FSM state constants
//   - NUM_DEN: number of denominations handled
package vm_pkg;

    localparam int NUM_DEN = 5;

    localparam logic [2:0] DEN_1  = 3'd0;
    localparam logic [2:0] DEN_5  = 3'd1;
    localparam logic [2:0] DEN_10 = 3'd2;
    localparam logic [2:0] DEN_20 = 3'd3;
    localparam logic [2:0] DEN_50 = 3'd4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SELECT = 2'd1;
    localparam state_t ST_REQ    = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic logic [5:0] value_of(input logic [2:0] d);
        logic [5:0] v;
        case (d)
            DEN_1:   v = 6'd1;
            DEN_5:   v = 6'd5;
            DEN_10:  v = 6'd10;
            DEN_20:  v = 6'd20;
            DEN_50:  v = 6'd50;
            default: v = 6'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// change_dispense_if: bundle of all non-clock signals of change_dispense_ctrl.
//   master: transaction FSM / dispenser / refill side (drives *_i, reads *_o)
//   slave : the payout controller itself
interface change_dispense_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 6
);
    logic             start_i;
    logic [AMT_W-1:0] change_amt_i;
    logic             disp_ack_i;
    logic             refill_i;
    logic [2:0]       refill_denom_i;
    logic [CNT_W-1:0] refill_cnt_i;
    logic             busy_o;
    logic             done_o;
    logic             short_o;
    logic             fault_o;
    logic [AMT_W-1:0] remaining_o;
    logic             disp_req_o;
    logic [2:0]       disp_denom_o;
    logic [4:0]       inv_empty_o;

    modport master (
        output start_i, change_amt_i, disp_ack_i, refill_i, refill_denom_i, refill_cnt_i,
        input  busy_o, done_o, short_o, fault_o, remaining_o, disp_req_o, disp_denom_o,
               inv_empty_o
    );

    modport slave (
        input  start_i, change_amt_i, disp_ack_i, refill_i, refill_denom_i, refill_cnt_i,
        output busy_o, done_o, short_o, fault_o, remaining_o, disp_req_o, disp_denom_o,
               inv_empty_o
    );
endinterface

// File: rtl/change_dispense_ctrl_coin_inventory.sv
// coin_inventory: one saturating item counter per denomination.
//   clk, rst        : clock, async active-high reset (counters load INIT_CNT)
//   refill_en/denom/cnt : add cnt to counter[denom], clamped at all-ones;
//                     codes >= NUM_DEN match no counter and are dropped
//   dec_en/dec_denom: remove one item; an empty counter stays at zero
//   counts          : all counter values
//   nonempty        : bit d set when counter d is non-zero
module coin_inventory
    import vm_pkg::*;
#(
    parameter int CNT_W    = 6,
    parameter int INIT_CNT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_en,
    input  logic [2:0]                      refill_denom,
    input  logic [CNT_W-1:0]                refill_cnt,
    input  logic                            dec_en,
    input  logic [2:0]                      dec_denom,
    output logic [NUM_DEN-1:0][CNT_W-1:0]   counts,
    output logic [NUM_DEN-1:0]              nonempty
);
    logic [NUM_DEN-1:0][CNT_W:0] sums;

    always_comb begin
        sums = '0;
        nonempty = '0;
        for (int d = 0; d < NUM_DEN; d++) begin
            sums[d]     = {1'b0, counts[d]} + {1'b0, refill_cnt};
            nonempty[d] = (counts[d] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NUM_DEN; d++) counts[d] <= CNT_W'(INIT_CNT);
        end else begin
            for (int d = 0; d < NUM_DEN; d++) begin
                if (refill_en && refill_denom == 3'(d)) begin
                    // carry out of the add means the counter would wrap: clamp
                    counts[d] <= sums[d][CNT_W] ? '1 : sums[d][CNT_W-1:0];
                end else if (dec_en && dec_denom == 3'(d) && nonempty[d]) begin
                    counts[d] <= counts[d] - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: pays out change greedily (50/20/10/5/1) through a
// single req/ack dispenser and tracks coin inventory.
//   sys_clk : system clock
//   sys_rst : async active-high reset; aborts any payout
//   bus     : change_dispense_if.slave (start/amount in, busy/done/short/
//             fault/remaining out, dispenser req/denom/ack, refill, inv_empty)
// Optional: define DISP_TIMEOUT_EN to add an ACK_TIMEOUT-cycle watchdog on
// the dispenser ack; without it fault_o is constant 0 and REQ waits forever.
//
//   state  | meaning
//   IDLE   | waiting for start_i; refills accepted here only
//   SELECT | choose largest affordable in-stock denomination, or finish
//   REQ    | disp_req_o high, waiting for disp_ack_i (or watchdog)
//   DONE   | done_o pulse with short_o, then back to IDLE
module change_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 6,
    parameter int INIT_CNT = 4
`ifdef DISP_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 1000
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    change_dispense_if.slave  bus
);
    state_t                         state;
    logic [AMT_W-1:0]               remaining;
    logic                           busy;
    logic                           done;
    logic                           short_flag;
    logic                           req;
    logic [2:0]                     denom;
    logic                           ack_taken;
    logic                           refill_ok;
    logic                           timeout;
    logic                           sel_found;
    logic [2:0]                     sel_d;
    logic [NUM_DEN-1:0][CNT_W-1:0]  inv_counts;
    logic [NUM_DEN-1:0]             inv_nonempty;

    assign ack_taken = (state == ST_REQ) && bus.disp_ack_i;
    assign refill_ok = (state == ST_IDLE) && bus.refill_i;

    coin_inventory #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_inv (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .refill_en    (refill_ok),
        .refill_denom (bus.refill_denom_i),
        .refill_cnt   (bus.refill_cnt_i),
        .dec_en       (ack_taken),
        .dec_denom    (denom),
        .counts       (inv_counts),
        .nonempty     (inv_nonempty)
    );

    // Ascending scan: the last hit is the largest usable denomination.
    always_comb begin
        sel_found = 1'b0;
        sel_d     = DEN_1;
        for (int d = 0; d < NUM_DEN; d++) begin
            if (inv_counts[d] != '0 && AMT_W'(value_of(3'(d))) <= remaining) begin
                sel_found = 1'b1;
                sel_d     = 3'(d);
            end
        end
    end

`ifdef DISP_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          fault;

    // Loaded while in SELECT so it is fresh on every REQ entry.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                           wd_cnt <= '0;
        else if (state == ST_SELECT)           wd_cnt <= TW'(ACK_TIMEOUT - 1);
        else if (state == ST_REQ && wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
    end

    assign timeout = (state == ST_REQ) && !bus.disp_ack_i && (wd_cnt == '0);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                                fault <= 1'b0;
        else if (state == ST_IDLE && bus.start_i)   fault <= 1'b0;
        else if (timeout)                           fault <= 1'b1;
    end

    assign bus.fault_o = fault;
`else
    assign timeout     = 1'b0;
    assign bus.fault_o = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short_flag <= 1'b0;
            req        <= 1'b0;
            denom      <= DEN_1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        remaining  <= bus.change_amt_i;
                        short_flag <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining != '0 && sel_found) begin
                        denom <= sel_d;
                        req   <= 1'b1;
                        state <= ST_REQ;
                    end else begin
                        // done/short registered on entry so they appear in DONE
                        done       <= 1'b1;
                        short_flag <= (remaining != '0);
                        state      <= ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (bus.disp_ack_i) begin
                        remaining <= remaining - AMT_W'(value_of(denom));
                        req       <= 1'b0;
                        state     <= ST_SELECT;
                    end else if (timeout) begin
                        req        <= 1'b0;
                        done       <= 1'b1;
                        short_flag <= (remaining != '0);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.short_o      = short_flag;
    assign bus.remaining_o  = remaining;
    assign bus.disp_req_o   = req;
    assign bus.disp_denom_o = denom;
    assign bus.inv_empty_o  = ~inv_nonempty;
endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
- Sequences physical change payout for the vending machine after a purchase completes.
- Takes a change amount from the transaction FSM and breaks it greedily into notes and coins of 50/20/10/5/1.
- Drives one dispenser per transaction with a req/ack handshake.
- Tracks a per-denomination inventory and reports any shortfall back to the display path.

Parameters:
AMT_W, 8, width of change amount and remaining amount (max 255 units)
CNT_W, 6, width of each inventory counter (saturates at 2^CNT_W-1)
INIT_CNT, 4, inventory count loaded into every denomination on reset
ACK_TIMEOUT, 1000, cycles to wait for disp_ack_i before fault (used only with DISP_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst  in  1  asynchronous reset, active-high
start_i  in  1  1-cycle pulse; latch change_amt_i and begin payout
change_amt_i  in  AMT_W  change owed, sampled on start_i
disp_ack_i  in  1  1-cycle pulse from dispenser: one item released
refill_i  in  1  1-cycle pulse; add refill_cnt_i to refill_denom_i
refill_denom_i  in  3  0=1,1=5,2=10,3=20,4=50; codes 5-7 ignored
refill_cnt_i  in  CNT_W  items added on refill
busy_o  out  1  high from cycle after start_i until done_o
done_o  out  1  1-cycle pulse at end of payout
short_o  out  1  registered with done_o; 1 if remaining_o != 0 at end; held until next start_i
fault_o  out  1  dispenser timeout flag; held until next start_i
remaining_o  out  AMT_W  amount still owed
disp_req_o  out  1  level request to dispenser
disp_denom_o  out  3  denomination code being requested; valid while disp_req_o
inv_empty_o  out  5  bit d = inventory[d]==0

Behaviour:
- Reset values:
  - All outputs 0.
  - remaining_o 0.
  - Inventory counters = INIT_CNT.
  - FSM in IDLE.
  - Reset mid-payout aborts immediately; disp_req_o drops asynchronously.
- FSM states: IDLE, SELECT, REQ, DONE.
- IDLE:
  - On start_i: remaining <= change_amt_i, clear short_o/fault_o, busy_o <= 1, go to SELECT.
  - start_i at any other state is ignored.
- SELECT (1 cycle):
  - If remaining==0, go to DONE.
  - Otherwise pick the largest denomination d with value(d) <= remaining and inv[d] > 0.
  - Register d into disp_denom_o, set disp_req_o <= 1, go to REQ.
  - If no such d exists, go to DONE (shortfall).
- REQ:
  - disp_req_o held high.
  - On disp_ack_i: remaining -= value(d), inv[d] -= 1, disp_req_o <= 0, go to SELECT.
- DONE (1 cycle):
  - done_o=1, short_o=(remaining!=0), busy_o <= 0, go to IDLE.
- disp_ack_i outside REQ is ignored.
- Latency:
  - start_i at cycle 0 → SELECT at cycle 1 → disp_req_o high at cycle 2.
  - Each item costs 2 cycles plus the dispenser's ack delay.
  - Zero change: done_o at cycle 2.
- Refill:
  - Accepted only in IDLE.
  - inv[refill_denom_i] saturates at 2^CNT_W-1.
  - Ignored while busy_o.
  - Refill and start_i in the same cycle: both take effect; SELECT sees the updated inventory.
- Arithmetic: subtraction never underflows because value(d) <= remaining is checked in SELECT. Inventory never decrements below 0.
- inv_empty_o is combinational from the counters.

Optional Feature:
- Macro: DISP_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in REQ; it clears on entry to REQ.
  - On reaching ACK_TIMEOUT without ack: fault_o <= 1, disp_req_o <= 0, go to DONE.
  - In that DONE: short_o=1 when remaining!=0; inventory is not decremented.
- Undefined:
  - No counter is present; REQ waits indefinitely.
  - fault_o is tied to 0.

Decomposition:
- Shared package vm_pkg:
  - Denomination code constants DEN_1..DEN_50.
  - value_of(d) function returning 1/5/10/20/50.
  - FSM state typedef.
  - NUM_DEN=5.
- Sub-module coin_inventory holds the 5 saturating counters:
  - Refill port.
  - Decrement port.
  - Non-empty vector.
  - Counts exported for the selection logic.

Test Plan:
- Defaults, change 38, ack 3 cycles after each req → denoms 20,10,5,1,1,1; done_o; short_o=0; remaining_o=0; inv[1]=1.
- change 0 → no disp_req_o; done_o at cycle 2 after start_i; short_o=0.
- Refill 1s to max, then deplete: inv[50]=1, change 100 → 50,20,20,10; short_o=0; inv[20]=2.
- Drain the 1s, then change 3 → no request; done_o; short_o=1; remaining_o=3; inv_empty_o[0]=1.
- DISP_TIMEOUT_EN, ACK_TIMEOUT=16, change 5, never ack → fault_o=1, short_o=1, remaining_o=5, inv[5] unchanged.
- Assert sys_rst while disp_req_o high → all outputs 0 immediately; inventory back to 4; next start_i behaves normally.
